apb_imem_loader: RTL and testbench

APB3 slave that sits directly upstream of `rv32i_pipelined_top`, between the system APB bus and the core's instruction memory write port. It turns zero/one-wait-state APB transfers into single-cycle instruction-memory writes/reads, and owns the `core_select` run-control bit. It also latches `run_complete` into a sticky done flag, so software can load a program, start the core and poll for completion without a bench driving core pins directly.

---
 rtl/rv32i_apb_pkg.sv | 48 ++++
 rtl/apb_imem_loader.sv | 165 ++++++++++++++++
 tb/tb_apb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_apb_pkg.sv
// Shared types and constants for the APB instruction-memory loader:
// FSM state encoding, register word addresses, CTRL bit positions and
// the APB address decoder.
package rv32i_apb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REGION_MEM  = 2'd0,
        REGION_CTRL = 2'd1,
        REGION_STAT = 2'd2,
        REGION_ERR  = 2'd3
    } region_t;

    localparam logic [31:0] CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] STAT_ADDR = 32'h8000_0001;

    // CTRL register bit positions
    localparam int CTRL_RUN_BIT   = 0;  // write/read: core_select
    localparam int CTRL_CLEAR_BIT = 1;  // write: clear word_count
    localparam int CTRL_DONE_BIT  = 1;  // read: sticky done flag

    // Classify an APB word address: anything below 2**mem_bits is memory,
    // two exact-match register addresses, everything else is an error.
    function automatic region_t decode_addr(
        input logic [31:0] addr,
        input int unsigned mem_bits,
        input logic [31:0] ctrl_addr,
        input logic [31:0] stat_addr
    );
        region_t region;
        if ((addr >> mem_bits) == 32'd0) begin
            region = REGION_MEM;
        end else if (addr == ctrl_addr) begin
            region = REGION_CTRL;
        end else if (addr == stat_addr) begin
            region = REGION_STAT;
        end else begin
            region = REGION_ERR;
        end
        return region;
    endfunction

endpackage

// File: rtl/apb_imem_loader.sv
// APB3 slave that loads/reads the core's instruction memory and owns the
// core_select run-control bit plus a sticky done flag set by run_complete.
// Memory writes and register accesses are zero-wait; memory reads take one
// wait state followed by a dead RESP cycle.
module apb_imem_loader #(
    parameter int          DATA_LENGTH    = 32,
    parameter int          ADDRESS_LENGTH = 11,
    parameter logic [31:0] CTRL_ADDR      = rv32i_apb_pkg::CTRL_ADDR,
    parameter logic [31:0] STAT_ADDR      = rv32i_apb_pkg::STAT_ADDR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               paddr,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_LENGTH-1:0]    pwdata,
    output logic [DATA_LENGTH-1:0]    prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      mem_we,
    output logic [ADDRESS_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0]    mem_wdata,
    input  logic [DATA_LENGTH-1:0]    mem_rdata,
    input  logic                      run_complete,
    output logic                      core_select,
    output logic                      load_active
);
    import rv32i_apb_pkg::*;

    localparam logic [ADDRESS_LENGTH:0] WC_MAX = {1'b1, {ADDRESS_LENGTH{1'b0}}};

    state_t                    state_reg;
    logic [ADDRESS_LENGTH-1:0] addr_reg;
    logic                      armed_reg;
    logic                      core_select_reg;
    logic                      done_reg;
    logic [ADDRESS_LENGTH:0]   word_count_reg;

    region_t                   region;
    logic                      access;
    logic                      idle_access;
    logic                      mem_hit;
    logic                      bad_access;
    logic                      start_read;
    logic                      ctrl_write;
    logic [DATA_LENGTH-1:0]    ctrl_word;
    logic [DATA_LENGTH-1:0]    stat_word;

    // armed_reg drops after any completed transfer and re-arms only once
    // penable goes low, so a held access phase is never accepted twice.
    // It also resets low so a transfer interrupted by reset must restart.
    assign region      = decode_addr(paddr, ADDRESS_LENGTH, CTRL_ADDR, STAT_ADDR);
    assign access      = psel & penable & armed_reg;
    assign idle_access = (state_reg == IDLE) & access;
    assign mem_hit     = (region == REGION_MEM);
    assign bad_access  = (region == REGION_ERR) | (mem_hit & core_select_reg);
    assign start_read  = idle_access & mem_hit & ~core_select_reg & ~pwrite;
    assign ctrl_write  = idle_access & (region == REGION_CTRL) & pwrite;
    assign core_select = core_select_reg;

    // Register read images: CTRL = {done, core_select}, STATUS = word_count.
    always_comb begin
        ctrl_word                         = '0;
        ctrl_word[CTRL_RUN_BIT]           = core_select_reg;
        ctrl_word[CTRL_DONE_BIT]          = done_reg;
        stat_word                         = '0;
        stat_word[ADDRESS_LENGTH:0]       = word_count_reg;
    end

    // APB response and memory port, decoded from state and the live bus.
    always_comb begin
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = addr_reg;
        case (state_reg)
            IDLE: begin
                mem_addr = paddr[ADDRESS_LENGTH-1:0];
                if (idle_access) begin
                    if (bad_access) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else if (mem_hit) begin
                        if (pwrite) begin
                            pready    = 1'b1;
                            mem_we    = 1'b1;
                            mem_wdata = pwdata;
                        end
                    end else begin
                        pready = 1'b1;
                        if (!pwrite) begin
                            prdata = (region == REGION_CTRL) ? ctrl_word : stat_word;
                        end
                    end
                end
            end
            RD_WAIT: begin
                pready = 1'b1;
                prdata = mem_rdata;
            end
            default: begin
            end
        endcase
        load_active = (state_reg != IDLE) | mem_we;
    end

    // Read FSM, latched read address and the re-arm flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            if (!penable) begin
                armed_reg <= 1'b1;
            end else if (pready) begin
                armed_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start_read) begin
                        addr_reg  <= paddr[ADDRESS_LENGTH-1:0];
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Run control, sticky done and loaded-word counter. A CTRL write owns
    // core_select over a coincident run_complete, but done still sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_select_reg <= 1'b0;
            done_reg        <= 1'b0;
            word_count_reg  <= '0;
        end else begin
            if (ctrl_write) begin
                core_select_reg <= pwdata[CTRL_RUN_BIT];
                if (pwdata[CTRL_RUN_BIT]) begin
                    done_reg <= 1'b0;
                end
                if (pwdata[CTRL_CLEAR_BIT]) begin
                    word_count_reg <= '0;
                end
            end
            if (run_complete && core_select_reg) begin
                done_reg <= 1'b1;
                if (!ctrl_write) begin
                    core_select_reg <= 1'b0;
                end
            end
            if (mem_we && (word_count_reg != WC_MAX)) begin
                word_count_reg <= word_count_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_imem_loader.sv
// Directed self-checking bench for apb_imem_loader with a small
// registered-read instruction memory model on the memory port.
module tb_apb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        run_complete = 1'b0;
    logic        core_select;
    logic        load_active;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_model [0:2047];

    logic [31:0] rd;
    logic        err;
    logic        we_seen;
    logic [10:0] we_addr;
    logic [31:0] we_data;
    int          waits;

    apb_imem_loader dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .run_complete(run_complete), .core_select(core_select),
        .load_active(load_active)
    );

    always #5 clk = ~clk;

    // Instruction memory model: write on strobe, data valid one cycle after address.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr];
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One APB transfer: setup, then access until pready (bounded).
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic rc, input bit quiet);
        bit fin;
        fin = 0; waits = 0; we_seen = 0; we_addr = '0; we_data = '0; rd = '0; err = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1; run_complete = rc;
        while (!fin && waits < 8) begin
            @(negedge clk);
            if (mem_we) begin we_seen = 1; we_addr = mem_addr; we_data = mem_wdata; end
            if (pready) begin rd = prdata; err = pslverr; fin = 1; end
            else waits++;
            @(posedge clk); #1;
            run_complete = 0;
        end
        psel = 0; penable = 0; pwrite = 0;
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no pready for addr %h after %0d cycles", addr, waits);
        end
        if (!quiet)
            $display("xfer %s addr=%h wdata=%h rdata=%h slverr=%0d waits=%0d mem_we=%0d",
                     wr ? "W" : "R", addr, data, rd, err, waits, we_seen);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({pready, pslverr, mem_we, core_select, load_active} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b expected 00000",
                              {pready, pslverr, mem_we, core_select, load_active}); end
        n_cmp++; if (prdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        n_cmp++; if (mem_addr !== 11'h0) begin
            n_bad++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_mem_write();
        apb_xfer(1, 32'd0, 32'h0050_0093, 0, 0);
        n_cmp++; if ({we_seen, err, waits[1:0]} !== 4'b1000) begin
            n_bad++; $display("FAIL wr0_resp: got we=%0d err=%0d waits=%0d expected 1 0 0", we_seen, err, waits); end
        n_cmp++; if (we_addr !== 11'd0 || we_data !== 32'h0050_0093) begin
            n_bad++; $display("FAIL wr0_port: got %h/%h expected 000/00500093", we_addr, we_data); end
        apb_xfer(1, 32'd1, 32'h0010_0113, 0, 0);
        n_cmp++; if (we_seen !== 1'b1 || we_addr !== 11'd1 || we_data !== 32'h0010_0113) begin
            n_bad++; $display("FAIL wr1_port: got %0d %h/%h expected 1 001/00100113", we_seen, we_addr, we_data); end
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'd2 || waits != 0) begin
            n_bad++; $display("FAIL status_after_wr: got %h waits=%0d expected 2 waits=0", rd, waits); end
    endtask

    task automatic test_mem_read();
        apb_xfer(0, 32'd1, 0, 0, 0);
        n_cmp++; if (waits != 1) begin
            n_bad++; $display("FAIL rd1_waits: got %0d expected 1", waits); end
        n_cmp++; if (rd !== 32'h0010_0113 || err !== 1'b0) begin
            n_bad++; $display("FAIL rd1_data: got %h err=%0d expected 00100113 err=0", rd, err); end
        apb_xfer(0, 32'd0, 0, 0, 0);
        n_cmp++; if (rd !== 32'h0050_0093) begin
            n_bad++; $display("FAIL rd0_data: got %h expected 00500093", rd); end
    endtask

    task automatic test_core_select();
        apb_xfer(1, 32'h8000_0000, 32'h1, 0, 0);
        n_cmp++; if (core_select !== 1'b1) begin
            n_bad++; $display("FAIL ctrl_set: got core_select=%0d expected 1", core_select); end
        apb_xfer(1, 32'd5, 32'hABCD_0001, 0, 0);
        n_cmp++; if (err !== 1'b1 || we_seen !== 1'b0) begin
            n_bad++; $display("FAIL wr_locked: got err=%0d we=%0d expected 1 0", err, we_seen); end
        apb_xfer(0, 32'd1, 0, 0, 0);
        n_cmp++; if (err !== 1'b1 || waits != 0 || rd !== 32'h0) begin
            n_bad++; $display("FAIL rd_locked: got err=%0d waits=%0d rd=%h expected 1 0 0", err, waits, rd); end
        apb_xfer(0, 32'h8000_0000, 0, 0, 0);
        n_cmp++; if (rd !== 32'h1) begin
            n_bad++; $display("FAIL ctrl_rd_run: got %h expected 1", rd); end
    endtask

    task automatic test_run_complete();
        @(posedge clk); #1; run_complete = 1;
        @(negedge clk);
        n_cmp++; if (core_select !== 1'b1) begin
            n_bad++; $display("FAIL rc_before_edge: got %0d expected 1", core_select); end
        @(posedge clk); #1; run_complete = 0;
        n_cmp++; if (core_select !== 1'b0) begin
            n_bad++; $display("FAIL rc_drop: got %0d expected 0", core_select); end
        apb_xfer(0, 32'h8000_0000, 0, 0, 0);
        n_cmp++; if (rd !== 32'h2) begin
            n_bad++; $display("FAIL ctrl_rd_done: got %h expected 2", rd); end
    endtask

    task automatic test_errors();
        apb_xfer(1, 32'h0000_0800, 32'h1111_2222, 0, 0);
        n_cmp++; if (err !== 1'b1 || we_seen !== 1'b0 || waits != 0) begin
            n_bad++; $display("FAIL wr_oob: got err=%0d we=%0d waits=%0d expected 1 0 0", err, we_seen, waits); end
        apb_xfer(0, 32'h1234_0000, 0, 0, 0);
        n_cmp++; if (err !== 1'b1 || rd !== 32'h0 || waits != 0) begin
            n_bad++; $display("FAIL rd_unmapped: got err=%0d rd=%h waits=%0d expected 1 0 0", err, rd, waits); end
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'd2) begin
            n_bad++; $display("FAIL status_unchanged: got %h expected 2", rd); end
        apb_xfer(1, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0);
        n_cmp++; if (err !== 1'b0) begin
            n_bad++; $display("FAIL status_wr_noerr: got err=%0d expected 0", err); end
    endtask

    task automatic test_ctrl_clear();
        apb_xfer(1, 32'h8000_0000, 32'h2, 0, 0);
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'd0) begin
            n_bad++; $display("FAIL status_cleared: got %h expected 0", rd); end
        apb_xfer(0, 32'h8000_0000, 0, 0, 0);
        n_cmp++; if (rd !== 32'h2) begin
            n_bad++; $display("FAIL done_kept: got %h expected 2", rd); end
        apb_xfer(1, 32'h8000_0000, 32'h1, 0, 0);
        apb_xfer(0, 32'h8000_0000, 0, 0, 0);
        n_cmp++; if (rd !== 32'h1) begin
            n_bad++; $display("FAIL done_cleared: got %h expected 1", rd); end
    endtask

    task automatic test_simultaneous();
        apb_xfer(1, 32'h8000_0000, 32'h1, 1, 0);
        n_cmp++; if (core_select !== 1'b1) begin
            n_bad++; $display("FAIL simul_cs: got %0d expected 1", core_select); end
        apb_xfer(0, 32'h8000_0000, 0, 0, 0);
        n_cmp++; if (rd !== 32'h3) begin
            n_bad++; $display("FAIL simul_ctrl: got %h expected 3", rd); end
        apb_xfer(1, 32'h8000_0000, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int we_cnt;
        int rdy_cnt;
        we_cnt = 0; rdy_cnt = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'd7; pwdata = 32'h0000_0011;
        @(posedge clk); #1;
        penable = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (pready) rdy_cnt++;
            @(posedge clk); #1;
        end
        psel = 0; penable = 0; pwrite = 0;
        $display("xfer W addr=00000007 wdata=00000011 held_access mem_we_pulses=%0d pready_cycles=%0d", we_cnt, rdy_cnt);
        n_cmp++; if (we_cnt != 1 || rdy_cnt != 1) begin
            n_bad++; $display("FAIL held_access: got we=%0d rdy=%0d expected 1 1", we_cnt, rdy_cnt); end
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'd1) begin
            n_bad++; $display("FAIL held_count: got %h expected 1", rd); end
    endtask

    task automatic test_reset_mid();
        apb_xfer(1, 32'h8000_0000, 32'h1, 0, 0);
        @(posedge clk); #2;
        rst = 1;
        #1;
        n_cmp++; if (core_select !== 1'b0) begin
            n_bad++; $display("FAIL rst_cs_async: got %0d expected 0", core_select); end
        @(posedge clk); #1;
        rst = 0;
        apb_xfer(1, 32'd3, 32'hDEAD_BEEF, 0, 0);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 32'd3;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #2;
        n_cmp++; if (pready !== 1'b1 || load_active !== 1'b1) begin
            n_bad++; $display("FAIL rd_wait_state: got rdy=%0d la=%0d expected 1 1", pready, load_active); end
        rst = 1;
        #1;
        n_cmp++; if ({pready, core_select, load_active, mem_we} !== 4'b0) begin
            n_bad++; $display("FAIL rst_mid_read: got %b expected 0000", {pready, core_select, load_active, mem_we}); end
        @(posedge clk); #1;
        n_cmp++; if ({pready, load_active, prdata} !== 34'b0) begin
            n_bad++; $display("FAIL rst_held: got rdy=%0d la=%0d prdata=%h expected 0", pready, load_active, prdata); end
        rst = 0;
        @(negedge clk);
        n_cmp++; if ({pready, mem_we} !== 2'b0) begin
            n_bad++; $display("FAIL rst_no_reaccept: got %b expected 00", {pready, mem_we}); end
        @(posedge clk); #1;
        psel = 0; penable = 0;
        $display("xfer R addr=00000003 interrupted by reset");
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'd0) begin
            n_bad++; $display("FAIL status_after_rst: got %h expected 0", rd); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2049; i++) apb_xfer(1, i % 2048, i, 0, 1);
        $display("xfer W 2049 quiet memory writes done");
        apb_xfer(0, 32'h8000_0001, 0, 0, 0);
        n_cmp++; if (rd !== 32'h800) begin
            n_bad++; $display("FAIL count_saturate: got %h expected 00000800", rd); end
        apb_xfer(0, 32'd2047, 0, 0, 0);
        n_cmp++; if (rd !== 32'd2047) begin
            n_bad++; $display("FAIL rd_top_word: got %h expected 000007ff", rd); end
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_mem_read();
        test_core_select();
        test_run_complete();
        test_errors();
        test_ctrl_clear();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
